// File: rtl/mem_wb_stage.sv
// Memory-to-writeback pipeline stage: one-entry retire slot, load extraction, writeback mux,
// register-file write port, forwarding tap and retired-instruction counter.
module mem_wb_stage #(
  parameter int XLEN = 64,
  parameter int PC_W = 64,
  parameter int IW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [IW-1:0]   in_instr,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [2:0]      in_funct3,
  input  logic            stall,
  input  logic            flush,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic [IW-1:0]   tr_instr,
  output logic [PC_W-1:0] tr_pc,
  output logic            wb_stall,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            ld_fault,
  output logic [63:0]     instret
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [IW-1:0]   instr;
    logic [4:0]      rd;
    logic            rd_we;
    wb_sel_e         wb_sel;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] mem_rdata;
    logic [2:0]      funct3;
  } slot_t;

  slot_t       slot_q, slot_d;
  logic        slot_v_q, slot_v_d;
  logic [63:0] instret_q, instret_d;

  logic            capture;
  logic            retire;
  logic            fault;
  logic            writes_rd;
  logic [2:0]      off;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ld_data;
  logic [PC_W-1:0] pc_plus4;
  logic [XLEN-1:0] wb_data;

  assign in_ready = !slot_v_q || !stall;
  assign capture  = in_valid && in_ready && !flush;
  assign retire   = slot_v_q && !stall;

  // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    slot_d   = slot_q;
    slot_v_d = slot_v_q;
    if (capture) begin
      slot_d.pc        = in_pc;
      slot_d.instr     = in_instr;
      slot_d.rd        = in_rd;
      slot_d.rd_we     = in_rd_we;
      slot_d.wb_sel    = wb_sel_e'(in_wb_sel);
      slot_d.alu       = in_alu;
      slot_d.imm       = in_imm;
      slot_d.mem_rdata = in_mem_rdata;
      slot_d.funct3    = in_funct3;
      slot_v_d         = 1'b1;
    end else if (!stall || flush) begin
      slot_v_d = 1'b0;
    end
  end

  assign instret_d = retire ? instret_q + 64'd1 : instret_q;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q    <= '0;
      slot_v_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      slot_q    <= slot_d;
      slot_v_q  <= slot_v_d;
      instret_q <= instret_d;
    end
  end

  // Memory data is doubleword-aligned; the low address bits pick the starting byte lane.
  assign off  = slot_q.alu[2:0];
  assign lane = slot_q.mem_rdata >> {off, 3'b000};

  always_comb begin
    ld_data = '0;
    unique case (slot_q.funct3)
      3'b000:  ld_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  ld_data = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b011:  ld_data = lane;
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      3'b110:  ld_data = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    fault = 1'b0;
    if (slot_q.wb_sel == WB_LOAD) begin
      unique case (slot_q.funct3)
        3'b001, 3'b101: fault = off[0];
        3'b010, 3'b110: fault = (off[1:0] != 2'b00);
        3'b011:         fault = (off != 3'b000);
        3'b111:         fault = 1'b1;
        default:        fault = 1'b0;
      endcase
    end
  end

  assign pc_plus4 = slot_q.pc + PC_W'(4);

  always_comb begin
    wb_data = slot_q.alu;
    unique case (slot_q.wb_sel)
      WB_ALU:  wb_data = slot_q.alu;
      WB_LOAD: wb_data = ld_data;
      WB_PC4:  wb_data = XLEN'(pc_plus4);
      WB_IMM:  wb_data = slot_q.imm;
      default: wb_data = slot_q.alu;
    endcase
  end

  // Forwarding ignores stall: a held slot still owns the newest value of its rd.
  assign writes_rd = slot_v_q && slot_q.rd_we && (slot_q.rd != 5'd0) && !fault;

  assign rf_we     = writes_rd && !stall;
  assign rf_rd     = slot_q.rd;
  assign rf_data   = wb_data;
  assign tr_instr  = slot_q.instr;
  assign tr_pc     = slot_q.pc;
  assign wb_stall  = !retire;
  assign fwd_valid = writes_rd;
  assign fwd_rd    = slot_q.rd;
  assign fwd_data  = wb_data;
  assign ld_fault  = retire && fault;
  assign instret   = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected writebacks are queued at capture and
// compared when the slot retires.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic [1:0]  in_wb_sel;
  logic [63:0] in_alu;
  logic [63:0] in_imm;
  logic [63:0] in_mem_rdata;
  logic [2:0]  in_funct3;
  logic        stall;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [63:0] rf_data;
  logic [31:0] tr_instr;
  logic [63:0] tr_pc;
  logic        wb_stall;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic        ld_fault;
  logic [63:0] instret;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(64), .PC_W(64), .IW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_wb_sel(in_wb_sel), .in_alu(in_alu),
    .in_imm(in_imm), .in_mem_rdata(in_mem_rdata), .in_funct3(in_funct3),
    .stall(stall), .flush(flush),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .tr_instr(tr_instr), .tr_pc(tr_pc),
    .wb_stall(wb_stall), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .ld_fault(ld_fault), .instret(instret)
  );

  typedef struct packed {
    logic        we;
    logic        fault;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  logic        m_v;
  logic [63:0] m_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: byte-by-byte load gather with alignment as a modulo test.
  function automatic exp_t model(input logic [63:0] pc, input logic [31:0] instr,
                                 input logic [4:0] rd, input logic rd_we, input logic [1:0] sel,
                                 input logic [63:0] alu, input logic [63:0] imm,
                                 input logic [63:0] rdata, input logic [2:0] f3);
    exp_t e;
    int   off;
    int   n;
    logic sbit;
    e       = '0;
    e.pc    = pc;
    e.instr = instr;
    e.rd    = rd;
    case (sel)
      2'b00: e.data = alu;
      2'b10: e.data = pc + 64'd4;
      2'b11: e.data = imm;
      default: begin
        off     = int'(alu[2:0]);
        n       = 1 << f3[1:0];
        e.fault = (f3 == 3'b111) || ((off % n) != 0);
        if (!e.fault) begin
          for (int i = 0; i < n; i++) e.data[8*i +: 8] = rdata[8*(off+i) +: 8];
          sbit = !f3[2] && e.data[8*n-1];
          for (int b = 8*n; b < 64; b++) e.data[b] = sbit;
        end
      end
    endcase
    e.we = rd_we && (rd != 5'd0) && !e.fault;
    return e;
  endfunction

  // Inputs are driven at the falling edge; outputs are checked 1 ns later, before the rising edge.
  task automatic step();
    logic exp_ready;
    logic retire;
    logic cap;
    exp_t e;
    #1;
    exp_ready = !m_v || !stall;
    retire    = m_v && !stall;
    check("in_ready", in_ready, exp_ready);
    check("wb_stall", wb_stall, !retire);
    check("instret", instret, m_cnt);
    if (m_v) begin
      e = sb_q[0];
      check("fwd_valid", fwd_valid, e.we);
      if (e.we) begin
        check("fwd_rd", fwd_rd, e.rd);
        check("fwd_data", fwd_data, e.data);
      end
    end else begin
      check("fwd_valid_idle", fwd_valid, 0);
    end
    if (retire) begin
      check("rf_we", rf_we, e.we);
      check("ld_fault", ld_fault, e.fault);
      check("tr_pc", tr_pc, e.pc);
      check("tr_instr", tr_instr, e.instr);
      if (e.we) begin
        check("rf_rd", rf_rd, e.rd);
        check("rf_data", rf_data, e.data);
      end
      void'(sb_q.pop_front());
      m_cnt++;
    end else begin
      check("rf_we_idle", rf_we, 0);
      check("ld_fault_idle", ld_fault, 0);
    end
    cap = in_valid && exp_ready && !flush;
    if (cap) begin
      sb_q.push_back(model(in_pc, in_instr, in_rd, in_rd_we, in_wb_sel, in_alu, in_imm,
                           in_mem_rdata, in_funct3));
      m_v = 1'b1;
    end else if (!stall || flush) begin
      if (m_v && !retire) void'(sb_q.pop_front());
      m_v = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] rd, input logic [1:0] sel, input logic [63:0] alu,
                       input logic [2:0] f3);
    in_valid  = 1'b1;
    in_pc     = 64'h8000_0000 + {50'd0, rd, 9'd0} + 64'(alu[7:0]);
    in_instr  = {27'h1ab_cdef, rd};
    in_rd     = rd;
    in_rd_we  = 1'b1;
    in_wb_sel = sel;
    in_alu    = alu;
    in_funct3 = f3;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst          = 1'b0;
    in_valid     = 1'b0;
    in_pc        = '0;
    in_instr     = '0;
    in_rd        = '0;
    in_rd_we     = 1'b0;
    in_wb_sel    = '0;
    in_alu       = '0;
    in_imm       = 64'h0000_0000_dead_b000;
    in_mem_rdata = 64'h8877_6655_4433_2211;
    in_funct3    = '0;
    stall        = 1'b0;
    flush        = 1'b0;
    m_v          = 1'b0;
    m_cnt        = '0;
    #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_wb_stall", wb_stall, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_fwd_valid", fwd_valid, 0);
    check("rst_instret", instret, 0);
    check("rst_rf_data", rf_data, 0);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back ALU ops
    drive(5'd1, 2'b00, 64'h11, 3'b000); step();
    drive(5'd2, 2'b00, 64'h22, 3'b000); step();
    drive(5'd3, 2'b00, 64'h33, 3'b000); step();
    idle();
    idle();
    check("instret_b2b", instret, 3);

    // Load extraction and misalignment
    drive(5'd4, 2'b01, 64'h1003, 3'b000); step();
    drive(5'd4, 2'b01, 64'h1006, 3'b001); step();
    drive(5'd4, 2'b01, 64'h1006, 3'b101); step();
    drive(5'd4, 2'b01, 64'h1004, 3'b010); step();
    drive(5'd4, 2'b01, 64'h1004, 3'b110); step();
    drive(5'd4, 2'b01, 64'h1000, 3'b011); step();
    drive(5'd4, 2'b01, 64'h1007, 3'b100); step();
    drive(5'd6, 2'b01, 64'h1002, 3'b010); step();
    drive(5'd6, 2'b01, 64'h1000, 3'b111); step();
    drive(5'd6, 2'b01, 64'h1001, 3'b001); step();
    drive(5'd7, 2'b10, 64'h40, 3'b000); step();
    drive(5'd8, 2'b11, 64'h0, 3'b000); step();
    idle();

    // Stall for 4 cycles with a held rd=5, upstream keeps offering
    drive(5'd5, 2'b00, 64'h55, 3'b000); step();
    drive(5'd9, 2'b00, 64'h99, 3'b000);
    stall = 1'b1;
    repeat (4) step();
    check("stall_fwd_valid", fwd_valid, 1);
    stall = 1'b0;
    step();
    idle();

    // Flush blocks capture; flush while retiring still writes
    drive(5'd10, 2'b00, 64'hA0, 3'b000);
    flush = 1'b1; step();
    flush = 1'b0; idle();
    drive(5'd11, 2'b00, 64'hB0, 3'b000); step();
    drive(5'd12, 2'b00, 64'hC0, 3'b000);
    flush = 1'b1; step();
    flush = 1'b0; idle();
    drive(5'd13, 2'b00, 64'hD0, 3'b000); step();
    stall = 1'b1; flush = 1'b1; in_valid = 1'b0; step();
    stall = 1'b0; flush = 1'b0; idle();
    drive(5'd0, 2'b00, 64'hE0, 3'b000); step();
    idle();

    // Asynchronous reset between edges while a slot is stalled
    drive(5'd14, 2'b00, 64'hF0, 3'b000); step();
    in_valid = 1'b0; stall = 1'b1;
    step();
    #2 rst = 1'b0;
    #1;
    check("arst_rf_we", rf_we, 0);
    check("arst_wb_stall", wb_stall, 1);
    check("arst_in_ready", in_ready, 1);
    check("arst_fwd_valid", fwd_valid, 0);
    check("arst_instret", instret, 0);
    check("arst_tr_pc", tr_pc, 0);
    check("arst_rf_data", rf_data, 0);
    sb_q.delete();
    m_v   = 1'b0;
    m_cnt = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    idle();
    idle();

    // Random traffic
    for (int k = 0; k < 150; k++) begin
      in_valid     = $urandom_range(0, 3) != 0;
      in_pc        = {$urandom, $urandom};
      in_instr     = $urandom;
      in_rd        = 5'($urandom_range(0, 31));
      in_rd_we     = $urandom_range(0, 3) != 0;
      in_wb_sel    = 2'($urandom_range(0, 3));
      in_alu       = {$urandom, $urandom};
      in_imm       = {$urandom, $urandom};
      in_mem_rdata = {$urandom, $urandom};
      in_funct3    = 3'($urandom_range(0, 7));
      stall        = $urandom_range(0, 3) == 0;
      flush        = $urandom_range(0, 9) == 0;
      step();
    end
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
